pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline-stage register; successor of the fixed IF/ID flush register.
//  Carries the decoded-control bundle, register addresses, immediate and PC between
//  pipeline stages, using a valid/ready handshake and a 2-entry skid buffer.
//  Provides full throughput, a registered in_ready and back-pressure (stall) support.
//  flush_i squashes every held entry and presents a NOP bubble. Sits between any two
//  stages (IF/ID, ID/EX, EX/MEM).
// PARAMETERS
//  XLEN      32             data width of imm/pc fields
//  CTRL_W    24             width of packed control bundle
//  CTRL_NOP  24'h000380     control pattern of a bubble (REG_WEN/DM_enable_n/DM_WEN inactive = 1)
//  CNT_W     16             width of saturating performance counters
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  flush_i      in   1       squash all held/incoming entries (taken branch/jump)
//  in_valid_i   in   1       upstream entry valid
//  in_ready_o   out  1       stage can accept; registered, no comb path from out_ready_i
//  in_ctrl_i    in   CTRL_W  control bundle
//  in_rs1_i     in   5       rs1 address
//  in_rs2_i     in   5       rs2 address
//  in_rd_i      in   5       rd address
//  in_imm_i     in   XLEN    immediate
//  in_pc_i      in   XLEN    PC
//  out_valid_o  out  1       downstream entry valid
//  out_ready_i  in   1       downstream accepts (0 = stall)
//  out_ctrl_o   out  CTRL_W  ; out_rs1_o/out_rs2_o/out_rd_o 5 ; out_imm_o/out_pc_o XLEN
//  flush_cnt_o  out  CNT_W   count of flush_i cycles, saturating
//  stall_cnt_o  out  CNT_W   count of cycles with out_valid_o & ~out_ready_i, saturating
// BEHAVIOUR
//  - State: EMPTY (no entry), ONE (main reg valid), FULL (main + skid valid).
//  - in_ready_o = (state != FULL); out_valid_o = (state != EMPTY). Both are pure state decodes.
//  - Accept = in_valid_i & in_ready_o; Send = out_valid_o & out_ready_i.
//  - EMPTY: accept -> ONE, main <= in.
//  - ONE: accept & send -> ONE, main <= in. accept & ~send -> FULL, skid <= in.
//    ~accept & send -> EMPTY. Otherwise hold.
//  - FULL: send -> ONE, main <= skid. Otherwise hold. Input is ignored (in_ready_o = 0).
//  - Latency 1 cycle from accept in EMPTY to out_valid_o; sustained throughput 1 entry per cycle.
//  - Outputs are always driven from the main register. Whenever the state enters EMPTY
//    (drain, flush or reset), main is loaded with the bubble: ctrl = CTRL_NOP, rs1/rs2/rd = 0,
//    imm = 0, pc = 0. A downstream stage that ignores valid therefore sees a NOP.
//  - flush_i has priority over every other event. Next state is EMPTY and main is loaded
//    with the bubble. An input accepted in the same cycle is discarded; the skid entry is
//    discarded. in_ready_o = 1 on the following cycle.
//  - A send coincident with flush_i counts as consumed by downstream. The payload shown
//    during that cycle is the pre-flush entry.
//  - Reset (rst = 1 at clk edge) overrides flush_i: state EMPTY, bubble in main, skid
//    cleared to the bubble, both counters 0, in_ready_o = 1, out_valid_o = 0.
//    Reset mid-transfer drops all entries.
//  - Counters: +1 per qualifying cycle, held at 2^CNT_W-1 (no wrap); frozen while rst = 1.
//  - Entry order is strictly FIFO; an entry is never duplicated or dropped except by flush/reset.
// STRUCTURE
//  - Package pipe_pkg: field widths (REG_ADDR_W = 5), CTRL_NOP default, state enum
//    {EMPTY, ONE, FULL}, and a payload-pack macro/function giving
//    PW = CTRL_W + 15 + 2*XLEN.
//  - One sub-module, pipe_slot: a PW-wide register with load/bubble controls, instantiated
//    twice (main, skid). The FSM and counters live in the top level.
// TESTING
//  1 Reset: rst = 1 for 2 cycles -> out_valid_o = 0, in_ready_o = 1, out_ctrl_o = 24'h000380,
//    out_pc_o = 0, both counters = 0.
//  2 Streaming: 8 back-to-back entries pc = 0x100..0x11C, out_ready_i = 1 -> identical
//    sequence 1 cycle later, no gaps, in_ready_o stays 1.
//  3 Stall: load pc = 0x200, 0x204, hold out_ready_i = 0 for 3 cycles -> FULL,
//    in_ready_o = 0, out_pc_o = 0x200, stall_cnt_o = 3. Release -> 0x200 then 0x204.
//  4 Flush in FULL while in_valid_i = 1 (pc = 0x208) -> next cycle out_valid_o = 0,
//    bubble payload, 0x204 and 0x208 never appear, flush_cnt_o = 1.
//  5 flush_i and rst asserted together in FULL -> reset result, flush_cnt_o = 0.
//  6 Saturation with CNT_W = 4: stall for 20 cycles -> stall_cnt_o = 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
//   REG_ADDR_W       : width of each register-address field (rs1/rs2/rd)
//   CTRL_NOP_DEFAULT : control pattern of a bubble (write enables held inactive)
//   state_e          : occupancy state of the stage
//   payload_w()      : packed payload width for a given control/data width
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [23:0] CTRL_NOP_DEFAULT = 24'h000380;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Payload layout, MSB first: ctrl | rs1 | rs2 | rd | imm | pc
  function automatic int payload_w(input int ctrl_w, input int xlen);
    return ctrl_w + 3 * REG_ADDR_W + 2 * xlen;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the pipeline stage.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, loads BUBBLE
//   load   : capture d
//   bubble : load BUBBLE (overrides load)
//   d      : next payload
//   q      : held payload
module pipe_slot #(
  parameter int            PW     = 8,
  parameter logic [PW-1:0] BUBBLE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          bubble,
  input  logic [PW-1:0] d,
  output logic [PW-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// Carries control bundle, register addresses, immediate and PC between stages.
//   clk, rst                 : clock and synchronous active-high reset
//   flush_i                  : squash all held and incoming entries
//   in_valid_i / in_ready_o  : upstream handshake (in_ready_o is a state decode)
//   in_*_i                   : upstream payload fields
//   out_valid_o / out_ready_i: downstream handshake
//   out_*_o                  : downstream payload, always from the main slot
//   flush_cnt_o, stall_cnt_o : saturating event counters
//
//   state | meaning
//   EMPTY | nothing held, main slot holds the bubble
//   ONE   | main slot valid
//   FULL  | main and skid slots valid, upstream is stalled
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_NOP_DEFAULT,
  parameter int                CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CTRL_W-1:0]     in_ctrl_i,
  input  logic [REG_ADDR_W-1:0] in_rs1_i,
  input  logic [REG_ADDR_W-1:0] in_rs2_i,
  input  logic [REG_ADDR_W-1:0] in_rd_i,
  input  logic [XLEN-1:0]       in_imm_i,
  input  logic [XLEN-1:0]       in_pc_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CTRL_W-1:0]     out_ctrl_o,
  output logic [REG_ADDR_W-1:0] out_rs1_o,
  output logic [REG_ADDR_W-1:0] out_rs2_o,
  output logic [REG_ADDR_W-1:0] out_rd_o,
  output logic [XLEN-1:0]       out_imm_o,
  output logic [XLEN-1:0]       out_pc_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int            PW     = payload_w(CTRL_W, XLEN);
  localparam logic [PW-1:0] BUBBLE = {CTRL_NOP, {(PW - CTRL_W){1'b0}}};

  state_e state_q, state_d;

  logic          accept, send;
  logic          main_load, main_from_skid, main_bubble;
  logic          skid_load, skid_bubble;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;

  logic [CNT_W-1:0] flush_cnt_q, stall_cnt_q;

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign send        = out_valid_o & out_ready_i;

  assign in_payload = {in_ctrl_i, in_rs1_i, in_rs2_i, in_rd_i, in_imm_i, in_pc_i};
  assign main_d     = main_from_skid ? skid_q : in_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_bubble    = 1'b0;
    skid_load      = 1'b0;
    skid_bubble    = 1'b0;
    if (flush_i) begin
      // A send in this cycle still completes; everything else is dropped.
      state_d     = EMPTY;
      main_bubble = 1'b1;
      skid_bubble = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && send) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (send) begin
            state_d     = EMPTY;
            main_bubble = 1'b1;
          end
        end
        FULL: begin
          if (send) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_bubble = 1'b1;
          skid_bubble = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.PW(PW), .BUBBLE(BUBBLE)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .bubble (main_bubble),
    .d      (main_d),
    .q      (main_q)
  );

  pipe_slot #(.PW(PW), .BUBBLE(BUBBLE)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .bubble (skid_bubble),
    .d      (in_payload),
    .q      (skid_q)
  );

  assign {out_ctrl_o, out_rs1_o, out_rs2_o, out_rd_o, out_imm_o, out_pc_o} = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush_i && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
      if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign flush_cnt_o = flush_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 24;
  localparam int CNT_W  = 4;
  localparam int TPW    = CTRL_W + 15 + 2 * XLEN;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [4:0]        in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0]   in_imm, in_pc, out_imm, out_pc;
  logic [CNT_W-1:0]  flush_cnt, stall_cnt;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic [TPW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CTRL_NOP(24'h000380), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_rs1_i    (in_rs1),
    .in_rs2_i    (in_rs2),
    .in_rd_i     (in_rd),
    .in_imm_i    (in_imm),
    .in_pc_i     (in_pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_rs1_o   (out_rs1),
    .out_rs2_o   (out_rs2),
    .out_rd_o    (out_rd),
    .out_imm_o   (out_imm),
    .out_pc_o    (out_pc),
    .flush_cnt_o (flush_cnt),
    .stall_cnt_o (stall_cnt)
  );

  // Distinct, recognisable payload derived from the PC.
  function automatic logic [TPW-1:0] mk(input logic [31:0] pc);
    logic [23:0] c;
    c = pc[23:0] ^ 24'h5A5A5A;
    return {c, pc[6:2], pc[7:3], pc[8:4], ~pc, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, record what must come out, advance past the edge.
  task automatic cyc(input bit v, input logic [31:0] pc, input bit fl, input bit rs, input bit ordy);
    logic [TPW-1:0] p;
    p = mk(pc);
    in_valid  = v;
    {in_ctrl, in_rs1, in_rs2, in_rd, in_imm, in_pc} = p;
    flush     = fl;
    rst       = rs;
    out_ready = ordy;
    if (v && in_ready && !fl && !rs) exp_q.push_back(p);
    @(posedge clk);
    #1;
    if (fl || rs) exp_q.delete();
  endtask

  // Scoreboard monitor: compares every entry the DUT hands downstream.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got pc %h, expected no entry", out_pc);
      end else begin
        logic [TPW-1:0] e;
        e = exp_q.pop_front();
        if ({out_ctrl, out_rs1, out_rs2, out_rd, out_imm, out_pc} !== e) begin
          n_bad++;
          $display("FAIL out_payload: got pc %h ctrl %h, expected pc %h ctrl %h",
                   out_pc, out_ctrl, e[63:32] ^ 32'hFFFF_FFFF, e[TPW-1 -: 24]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {in_ctrl, in_rs1, in_rs2, in_rd, in_imm, in_pc} = '0;

    // Reset
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ctrl", 32'(out_ctrl), 32'h380);
    chk("rst_pc", out_pc, 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    mon_en = 1'b1;

    // Streaming: 8 back-to-back entries
    for (int i = 0; i < 8; i++) begin
      chk("stream_in_ready", 32'(in_ready), 1);
      if (i > 0) chk("stream_out_valid", 32'(out_valid), 1);
      cyc(1, 32'h100 + 32'(4 * i), 0, 0, 1);
    end
    chk("stream_last_valid", 32'(out_valid), 1);
    cyc(0, 0, 0, 0, 1);
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_bubble_pc", out_pc, 0);
    chk("drain_bubble_ctrl", 32'(out_ctrl), 32'h380);

    // Stall into FULL
    cyc(1, 32'h200, 0, 0, 0);
    cyc(1, 32'h204, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_out_pc", out_pc, 32'h200);
    chk("full_stall_cnt", 32'(stall_cnt), 3);
    cyc(0, 0, 0, 0, 1);
    chk("release_pc", out_pc, 32'h204);
    cyc(0, 0, 0, 0, 1);
    chk("release_empty", 32'(out_valid), 0);

    // Flush in FULL with an incoming entry
    cyc(1, 32'h200, 0, 0, 0);
    cyc(1, 32'h204, 0, 0, 0);
    cyc(1, 32'h208, 1, 0, 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_pc", out_pc, 0);
    chk("flush_ctrl", 32'(out_ctrl), 32'h380);
    chk("flush_cnt_1", 32'(flush_cnt), 1);
    chk("flush_stall_cnt", 32'(stall_cnt), 5);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Send coincident with flush is consumed
    cyc(1, 32'h400, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("flush_send_valid", 32'(out_valid), 0);
    chk("flush_cnt_2", 32'(flush_cnt), 2);
    chk("flush_send_queue", 32'(exp_q.size()), 0);

    // Flush and reset together in FULL
    cyc(1, 32'h500, 0, 0, 0);
    cyc(1, 32'h504, 0, 0, 0);
    chk("pre_rst_in_ready", 32'(in_ready), 0);
    cyc(1, 32'h508, 1, 1, 0);
    chk("rstfl_out_valid", 32'(out_valid), 0);
    chk("rstfl_in_ready", 32'(in_ready), 1);
    chk("rstfl_pc", out_pc, 0);
    chk("rstfl_flush_cnt", 32'(flush_cnt), 0);
    chk("rstfl_stall_cnt", 32'(stall_cnt), 0);
    cyc(0, 0, 0, 0, 1);

    // Stall counter saturation
    cyc(1, 32'h600, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    chk("sat_stall_cnt", 32'(stall_cnt), 15);
    chk("sat_out_pc", out_pc, 32'h600);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("end_out_valid", 32'(out_valid), 0);
    chk("end_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
